// File: rtl/slt_serial_seq.sv
// Bit-serial set-less-than sequencer for the MIPS ALU slow path.
// Two captured operands are shifted LSB first through one slt_1bit cell.
// The lt/eq/gt chain is closed through registered accumulators, and the
// SLT/SLTU result is presented after WIDTH cycles with a start/done handshake.

// One-bit magnitude comparator stage. Bits are processed LSB first, so the
// current bit outranks everything already accumulated. A differing bit
// decides the comparison. An equal bit passes the incoming chain through.
module slt_1bit (
   input  logic a,
   input  logic b,
   input  logic lti,
   input  logic eqi,
   input  logic gti,
   output logic lto,
   output logic eqo,
   output logic gto
);

   logic same;

   assign same = ~(a ^ b);
   assign lto  = (~a & b) | (same & lti);
   assign eqo  = same & eqi;
   assign gto  = (a & ~b) | (same & gti);

endmodule

module slt_serial_seq #(
   parameter int WIDTH = 32,
   parameter int CW    = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] rs,
   input  logic [WIDTH-1:0] rt,
   output logic             busy,
   output logic             done,
   output logic             lt,
   output logic             eq,
   output logic             gt,
   output logic [WIDTH-1:0] slt_out
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nx;

   logic [WIDTH-1:0] sr_rs;
   logic [WIDTH-1:0] sr_rt;
   logic             sgn;
   logic [CW-1:0]    cnt;
   logic             acc_lt;
   logic             acc_eq;
   logic             acc_gt;

   logic             last_bit;
   logic             swap;
   logic             accept;
   logic             cell_a;
   logic             cell_b;
   logic             cell_lt;
   logic             cell_eq;
   logic             cell_gt;

   // The sign bit is the last one processed; for a signed compare a set
   // sign bit means "smaller", so the cell operands are swapped there only.
   assign last_bit = (cnt == CW'(WIDTH - 1));
   assign swap     = last_bit & sgn;
   assign cell_a   = swap ? sr_rt[0] : sr_rs[0];
   assign cell_b   = swap ? sr_rs[0] : sr_rt[0];

   // New requests are only taken when nothing is in flight.
   assign accept   = start && ((state == IDLE) || (state == DONE));

   slt_1bit u_cell (
      .a   (cell_a),
      .b   (cell_b),
      .lti (acc_lt),
      .eqi (acc_eq),
      .gti (acc_gt),
      .lto (cell_lt),
      .eqo (cell_eq),
      .gto (cell_gt)
   );

   // State register; reset always returns to IDLE, aborting any compare.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state logic plus the busy/done status decoded from the state.
   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      done     = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nx = SHIFT;
            end
         end
         SHIFT: begin
            busy = 1'b1;
            if (last_bit) begin
               state_nx = DONE;
            end
         end
         DONE: begin
            done = 1'b1;
            if (start) begin
               state_nx = SHIFT;
            end else begin
               state_nx = IDLE;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // Operand capture, serial shifting, chain accumulation and result load.
   // Results are loaded straight from the cell on the final bit so they are
   // valid in the same cycle done rises, and they persist across new starts.
   always_ff @(posedge clk) begin
      if (rst) begin
         sr_rs   <= '0;
         sr_rt   <= '0;
         sgn     <= 1'b0;
         cnt     <= '0;
         acc_lt  <= 1'b0;
         acc_eq  <= 1'b1;
         acc_gt  <= 1'b0;
         lt      <= 1'b0;
         eq      <= 1'b0;
         gt      <= 1'b0;
         slt_out <= '0;
      end else if (accept) begin
         sr_rs   <= rs;
         sr_rt   <= rt;
         sgn     <= is_signed;
         cnt     <= '0;
         acc_lt  <= 1'b0;
         acc_eq  <= 1'b1;
         acc_gt  <= 1'b0;
      end else if (state == SHIFT) begin
         acc_lt  <= cell_lt;
         acc_eq  <= cell_eq;
         acc_gt  <= cell_gt;
         sr_rs   <= sr_rs >> 1;
         sr_rt   <= sr_rt >> 1;
         cnt     <= cnt + CW'(1);
         if (last_bit) begin
            lt      <= cell_lt;
            eq      <= cell_eq;
            gt      <= cell_gt;
            slt_out <= {{(WIDTH - 1){1'b0}}, cell_lt};
         end
      end
   end

endmodule

// File: tb/tb_slt_serial_seq.sv
// Self-checking bench for slt_serial_seq: a 32-bit instance for directed,
// handshake, reset and random checks, and a 4-bit instance swept exhaustively.
module tb_slt_serial_seq;

   logic        clk;
   logic        rst;

   logic        start;
   logic        is_signed;
   logic [31:0] rs;
   logic [31:0] rt;
   logic        busy;
   logic        done;
   logic        lt;
   logic        eq;
   logic        gt;
   logic [31:0] slt_out;

   logic        start4;
   logic        is_signed4;
   logic [3:0]  rs4;
   logic [3:0]  rt4;
   logic        busy4;
   logic        done4;
   logic        lt4;
   logic        eq4;
   logic        gt4;
   logic [3:0]  slt_out4;

   int total;
   int bad;

   typedef struct {
      logic        s;
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  exp;
   } vec_t;

   vec_t tbl[9];

   slt_serial_seq #(.WIDTH(32), .CW(6)) dut32 (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .is_signed (is_signed),
      .rs        (rs),
      .rt        (rt),
      .busy      (busy),
      .done      (done),
      .lt        (lt),
      .eq        (eq),
      .gt        (gt),
      .slt_out   (slt_out)
   );

   slt_serial_seq #(.WIDTH(4), .CW(2)) dut4 (
      .clk       (clk),
      .rst       (rst),
      .start     (start4),
      .is_signed (is_signed4),
      .rs        (rs4),
      .rt        (rt4),
      .busy      (busy4),
      .done      (done4),
      .lt        (lt4),
      .eq        (eq4),
      .gt        (gt4),
      .slt_out   (slt_out4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: interpret operands as integers and compare; returns {lt,eq,gt}.
   function automatic logic [2:0] refCmp(input logic s, input logic [31:0] a,
                                         input logic [31:0] b, input int w);
      longint va;
      longint vb;
      va = longint'(a);
      vb = longint'(b);
      if (s && a[w-1]) va = va - (longint'(1) << w);
      if (s && b[w-1]) vb = vb - (longint'(1) << w);
      return {va < vb, va == vb, va > vb};
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act,
                              input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Caller is at a negedge. Presents a request, drops start after the edge,
   // scrambles the inputs, then counts edges until done (bounded).
   task automatic applyStimulus(input bit sel, input logic s, input logic [31:0] a,
                                input logic [31:0] b, output int lat, output int busyCnt);
      if (sel) begin
         start4 = 1'b1; is_signed4 = s; rs4 = a[3:0]; rt4 = b[3:0];
      end else begin
         start = 1'b1; is_signed = s; rs = a; rt = b;
      end
      @(negedge clk);
      if (sel) begin
         start4 = 1'b0; is_signed4 = ~s; rs4 = 4'($urandom); rt4 = 4'($urandom);
      end else begin
         start = 1'b0; is_signed = ~s; rs = $urandom; rt = $urandom;
      end
      lat = 0;
      busyCnt = 0;
      while (lat < 100) begin
         if (sel ? done4 : done) break;
         if (sel ? busy4 : busy) busyCnt++;
         @(negedge clk);
         lat++;
      end
   endtask

   initial begin
      int lat;
      int busyCnt;
      int dones;
      int firstDone;
      logic [2:0] res;
      logic [2:0] exp;
      logic s;
      logic [31:0] a;
      logic [31:0] b;

      total = 0;
      bad = 0;
      start = 0; is_signed = 0; rs = '0; rt = '0;
      start4 = 0; is_signed4 = 0; rs4 = '0; rt4 = '0;

      tbl[0] = '{1'b0, 32'd5,        32'd7,        3'b100};
      tbl[1] = '{1'b1, 32'hFFFFFFFF, 32'h00000001, 3'b100};
      tbl[2] = '{1'b0, 32'hFFFFFFFF, 32'h00000001, 3'b001};
      tbl[3] = '{1'b0, 32'hA5A5A5A5, 32'hA5A5A5A5, 3'b010};
      tbl[4] = '{1'b1, 32'hA5A5A5A5, 32'hA5A5A5A5, 3'b010};
      tbl[5] = '{1'b1, 32'h80000000, 32'h7FFFFFFF, 3'b100};
      tbl[6] = '{1'b0, 32'h80000000, 32'h7FFFFFFF, 3'b001};
      tbl[7] = '{1'b1, 32'h7FFFFFFF, 32'h80000000, 3'b001};
      tbl[8] = '{1'b1, 32'h00000000, 32'h00000000, 3'b010};

      // Reset state
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("reset_busy", 64'(busy), 64'd0);
      checkOutput("reset_done", 64'(done), 64'd0);
      checkOutput("reset_flags", 64'({lt, eq, gt}), 64'd0);
      checkOutput("reset_slt", 64'(slt_out), 64'd0);
      checkOutput("reset_flags4", 64'({lt4, eq4, gt4, done4, busy4}), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      // Directed table
      for (int i = 0; i < 9; i++) begin
         applyStimulus(1'b0, tbl[i].s, tbl[i].a, tbl[i].b, lat, busyCnt);
         checkOutput($sformatf("tbl%0d_latency", i), 64'(lat), 64'd32);
         checkOutput($sformatf("tbl%0d_busy", i), 64'(busyCnt), 64'd32);
         checkOutput($sformatf("tbl%0d_flags", i), 64'({lt, eq, gt}), 64'(tbl[i].exp));
         checkOutput($sformatf("tbl%0d_slt", i), 64'(slt_out), 64'(tbl[i].exp[2]));
         @(negedge clk);
         checkOutput($sformatf("tbl%0d_done_pulse", i), 64'(done), 64'd0);
         checkOutput($sformatf("tbl%0d_hold", i), 64'({lt, eq, gt}), 64'(tbl[i].exp));
      end

      // start pulses during SHIFT are ignored
      start = 1'b1; is_signed = 1'b0; rs = 32'd5; rt = 32'd7;
      dones = 0;
      firstDone = -1;
      res = 3'b000;
      for (int c = 0; c < 45; c++) begin
         @(negedge clk);
         if (c == 3 || c == 10) begin
            start = 1'b1; rs = 32'd900; rt = 32'd2;
         end else begin
            start = 1'b0; rs = 32'd1; rt = 32'd0;
         end
         if (done) begin
            dones++;
            if (firstDone < 0) begin
               firstDone = c;
               res = {lt, eq, gt};
            end
         end
      end
      checkOutput("ignore_done_count", 64'(dones), 64'd1);
      checkOutput("ignore_latency", 64'(firstDone), 64'd32);
      checkOutput("ignore_result", 64'(res), 64'b100);

      // Back-to-back: start asserted in the DONE cycle
      applyStimulus(1'b0, 1'b0, 32'd100, 32'd3, lat, busyCnt);
      checkOutput("b2b_first_flags", 64'({lt, eq, gt}), 64'b001);
      applyStimulus(1'b0, 1'b1, 32'hFFFFFFFE, 32'd3, lat, busyCnt);
      checkOutput("b2b_latency", 64'(lat), 64'd32);
      checkOutput("b2b_busy", 64'(busyCnt), 64'd32);
      checkOutput("b2b_second_flags", 64'({lt, eq, gt}), 64'b100);

      // Reset mid-operation
      @(negedge clk);
      start = 1'b1; is_signed = 1'b0; rs = 32'd1; rt = 32'd2;
      @(negedge clk);
      start = 1'b0;
      repeat (15) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("midrst_busy", 64'(busy), 64'd0);
      checkOutput("midrst_done", 64'(done), 64'd0);
      checkOutput("midrst_flags", 64'({lt, eq, gt}), 64'd0);
      checkOutput("midrst_slt", 64'(slt_out), 64'd0);
      dones = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) dones++;
      end
      checkOutput("midrst_no_done", 64'(dones), 64'd0);
      applyStimulus(1'b0, 1'b0, 32'd1, 32'd2, lat, busyCnt);
      checkOutput("midrst_restart_latency", 64'(lat), 64'd32);
      checkOutput("midrst_restart_flags", 64'({lt, eq, gt}), 64'b100);
      @(negedge clk);

      // Randomized 32-bit compares against the reference model
      for (int i = 0; i < 30; i++) begin
         s = 1'($urandom);
         a = $urandom;
         b = (i % 5 == 0) ? a : $urandom;
         if (i % 7 == 0) b = a ^ 32'h80000000;
         exp = refCmp(s, a, b, 32);
         applyStimulus(1'b0, s, a, b, lat, busyCnt);
         checkOutput($sformatf("rand%0d_latency", i), 64'(lat), 64'd32);
         checkOutput($sformatf("rand%0d_flags s=%0d a=%h b=%h", i, s, a, b),
                     64'({lt, eq, gt}), 64'(exp));
         checkOutput($sformatf("rand%0d_slt", i), 64'(slt_out), 64'(exp[2]));
         if (i % 2 == 0) @(negedge clk);
      end

      // Exhaustive sweep of the 4-bit instance
      for (int sv = 0; sv < 2; sv++) begin
         for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
               exp = refCmp(1'(sv), 32'(x), 32'(y), 4);
               applyStimulus(1'b1, 1'(sv), 32'(x), 32'(y), lat, busyCnt);
               checkOutput($sformatf("w4_latency s=%0d %0d,%0d", sv, x, y), 64'(lat), 64'd4);
               checkOutput($sformatf("w4_flags s=%0d %0d,%0d", sv, x, y),
                           64'({lt4, eq4, gt4, slt_out4}), 64'({exp, 3'b000, exp[2]}));
            end
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
